// File: rtl/uart_sys_ctrl.sv
// Command sequencer behind the UART receiver: decodes framed register/ALU
// commands from the RX byte stream and pushes response bytes to the TX FIFO.
module uart_sys_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_OUT_WIDTH = 16,
  parameter int ALU_FUN_WIDTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     OUT_Valid,
  input  logic                     FIFO_FULL,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDR_WIDTH-1:0]    Address,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic                     ALU_EN,
  output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  output logic                     CLK_EN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FN  = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_RD,
    ALU_A, ALU_B, ALU_FN, ALU_WAIT, TX_LO, TX_HI
  } state_t;

  state_t                   state, state_n;
  logic [DATA_WIDTH-1:0]    rd_q, rd_n;
  logic [ALU_OUT_WIDTH-1:0] res_q, res_n;
  logic [ADDR_WIDTH-1:0]    addr_n;
  logic [DATA_WIDTH-1:0]    wdata_n, txd_n;
  logic [ALU_FUN_WIDTH-1:0] fun_n;
  logic                     wr_n, rden_n, alu_en_n, tx_vld_n;

  // Every strobe and data output is computed here and registered below, so
  // each one lands the cycle after the event that triggers it.
  always_comb begin
    state_n  = state;
    rd_n     = rd_q;
    res_n    = res_q;
    addr_n   = Address;
    wdata_n  = WrData;
    fun_n    = ALU_FUN;
    txd_n    = TX_P_DATA;
    wr_n     = 1'b0;
    rden_n   = 1'b0;
    alu_en_n = 1'b0;
    tx_vld_n = 1'b0;
    case (state)
      IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          CMD_WR:  state_n = WR_ADDR;
          CMD_RD:  state_n = RD_ADDR;
          CMD_ALU: state_n = ALU_A;
          CMD_FN:  state_n = ALU_FN;
          default: state_n = IDLE;
        endcase
      end
      WR_ADDR: if (RX_D_VLD) begin
        addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_n = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        wdata_n = RX_P_DATA;
        wr_n    = 1'b1;
        state_n = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
        rden_n  = 1'b1;
        state_n = RD_WAIT;
      end
      RD_WAIT: if (RdData_Valid) begin
        rd_n    = RdData;
        state_n = TX_RD;
      end
      TX_RD: if (!FIFO_FULL) begin
        txd_n    = rd_q;
        tx_vld_n = 1'b1;
        state_n  = IDLE;
      end
      // Operands go to the fixed ALU operand registers at addresses 0 and 1.
      ALU_A: if (RX_D_VLD) begin
        addr_n  = '0;
        wdata_n = RX_P_DATA;
        wr_n    = 1'b1;
        state_n = ALU_B;
      end
      ALU_B: if (RX_D_VLD) begin
        addr_n  = ADDR_WIDTH'(1);
        wdata_n = RX_P_DATA;
        wr_n    = 1'b1;
        state_n = ALU_FN;
      end
      ALU_FN: if (RX_D_VLD) begin
        fun_n    = RX_P_DATA[ALU_FUN_WIDTH-1:0];
        alu_en_n = 1'b1;
        state_n  = ALU_WAIT;
      end
      ALU_WAIT: if (OUT_Valid) begin
        res_n   = ALU_OUT;
        state_n = TX_LO;
      end
      TX_LO: if (!FIFO_FULL) begin
        txd_n    = res_q[DATA_WIDTH-1:0];
        tx_vld_n = 1'b1;
        state_n  = TX_HI;
      end
      TX_HI: if (!FIFO_FULL) begin
        txd_n    = res_q[ALU_OUT_WIDTH-1 -: DATA_WIDTH];
        tx_vld_n = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      rd_q      <= '0;
      res_q     <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      ALU_EN    <= 1'b0;
      CLK_EN    <= 1'b0;
      TX_D_VLD  <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      ALU_FUN   <= '0;
      TX_P_DATA <= '0;
    end else begin
      state     <= state_n;
      rd_q      <= rd_n;
      res_q     <= res_n;
      WrEn      <= wr_n;
      RdEn      <= rden_n;
      ALU_EN    <= alu_en_n;
      // ALU clock runs from the ALU_EN cycle until the cycle after OUT_Valid.
      CLK_EN    <= (state_n == ALU_WAIT);
      TX_D_VLD  <= tx_vld_n;
      Address   <= addr_n;
      WrData    <= wdata_n;
      ALU_FUN   <= fun_n;
      TX_P_DATA <= txd_n;
    end
  end

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// Bench for uart_sys_ctrl: register-file/ALU responders, an event monitor and
// a command-level reference model that predicts writes, reads, ALU starts and TX bytes.
module tb_uart_sys_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = 8'h00;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  RdData = 8'h00;
  logic        RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        OUT_Valid = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD;
  logic [3:0]  Address, ALU_FUN;
  logic [7:0]  WrData, TX_P_DATA;

  uart_sys_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT),
    .OUT_Valid(OUT_Valid), .FIFO_FULL(FIFO_FULL), .WrEn(WrEn), .RdEn(RdEn),
    .Address(Address), .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLK_EN(CLK_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0, n_err = 0;
  int cyc = 0, ce_cnt = 0, full_viol = 0, last_rx_cyc = 0;
  int rf_lat = 2, alu_lat = 3;
  logic        ce_at_en = 1'b0;
  logic        alu_force = 1'b0;
  logic [15:0] alu_force_val = 16'h0000;
  logic [7:0]  ref_regs [16] = '{default: 8'h00};
  logic [7:0]  env_regs [16] = '{default: 8'h00};

  logic [11:0] mon_wr[$], exp_wr[$];
  logic [3:0]  mon_rd[$], exp_rd[$], mon_alu[$], exp_alu[$];
  logic [7:0]  mon_tx[$], exp_tx[$];
  int          mon_rdc[$], mon_txc[$];

  function automatic logic [15:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {a, b};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  // Register file: writes land immediately, reads answer rf_lat cycles after RdEn.
  int rf_cnt = 0;
  logic [3:0] rf_addr = 4'h0;
  always @(negedge CLK) begin
    RdData_Valid = 1'b0;
    if (!RST) rf_cnt = 0;
    else begin
      if (rf_cnt > 0) begin
        rf_cnt--;
        if (rf_cnt == 0) begin RdData_Valid = 1'b1; RdData = env_regs[rf_addr]; end
      end
      if (RdEn) begin rf_cnt = rf_lat; rf_addr = Address; end
      if (WrEn) env_regs[Address] = WrData;
    end
  end

  // ALU: result alu_lat cycles after ALU_EN, computed from operand registers 0/1.
  int alu_cnt = 0;
  logic [3:0] alu_fun_q = 4'h0;
  always @(negedge CLK) begin
    OUT_Valid = 1'b0;
    if (!RST) alu_cnt = 0;
    else begin
      if (alu_cnt > 0) begin
        alu_cnt--;
        if (alu_cnt == 0) begin
          OUT_Valid = 1'b1;
          ALU_OUT = alu_force ? alu_force_val : alu_ref(env_regs[0], env_regs[1], alu_fun_q);
        end
      end
      if (ALU_EN) begin alu_cnt = alu_lat; alu_fun_q = ALU_FUN; end
    end
  end

  always @(negedge CLK) begin
    cyc++;
    if (WrEn) mon_wr.push_back({Address, WrData});
    if (RdEn) begin mon_rd.push_back(Address); mon_rdc.push_back(cyc); end
    if (ALU_EN) begin mon_alu.push_back(ALU_FUN); ce_at_en = CLK_EN; end
    if (TX_D_VLD) begin
      mon_tx.push_back(TX_P_DATA);
      mon_txc.push_back(cyc);
      if (FIFO_FULL) full_viol++;
    end
    if (CLK_EN) ce_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic send_byte(logic [7:0] b, int gap);
    RX_P_DATA = b; RX_D_VLD = 1'b1; last_rx_cyc = cyc + 1;
    step();
    RX_D_VLD = 1'b0; RX_P_DATA = 8'($urandom);
    repeat (gap) step();
  endtask

  task automatic settle();
    int n = 0;
    while (mon_tx.size() < exp_tx.size() && n < 300) begin step(); n++; end
    if (n >= 300) chk("settle_timeout", 32'(mon_tx.size()), 32'(exp_tx.size()));
    repeat (6) step();
  endtask

  task automatic compare_all(string tag);
    chk({tag, ".wr_count"}, 32'(mon_wr.size()), 32'(exp_wr.size()));
    foreach (exp_wr[i]) if (i < mon_wr.size()) chk({tag, ".wr"}, 32'(mon_wr[i]), 32'(exp_wr[i]));
    chk({tag, ".rd_count"}, 32'(mon_rd.size()), 32'(exp_rd.size()));
    foreach (exp_rd[i]) if (i < mon_rd.size()) chk({tag, ".rd_addr"}, 32'(mon_rd[i]), 32'(exp_rd[i]));
    chk({tag, ".alu_count"}, 32'(mon_alu.size()), 32'(exp_alu.size()));
    foreach (exp_alu[i]) if (i < mon_alu.size()) chk({tag, ".alu_fun"}, 32'(mon_alu[i]), 32'(exp_alu[i]));
    chk({tag, ".tx_count"}, 32'(mon_tx.size()), 32'(exp_tx.size()));
    foreach (exp_tx[i]) if (i < mon_tx.size()) chk({tag, ".tx"}, 32'(mon_tx[i]), 32'(exp_tx[i]));
    mon_wr.delete(); exp_wr.delete(); mon_rd.delete(); exp_rd.delete();
    mon_alu.delete(); exp_alu.delete(); mon_tx.delete(); exp_tx.delete();
    mon_rdc.delete(); mon_txc.delete();
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, Address, WrData, ALU_FUN, TX_P_DATA});
  endfunction

  task automatic do_wr(logic [7:0] a, logic [7:0] d);
    send_byte(8'hAA, $urandom_range(0, 2));
    send_byte(a, $urandom_range(0, 2));
    send_byte(d, 0);
    exp_wr.push_back({a[3:0], d});
    ref_regs[a[3:0]] = d;
    settle();
    compare_all("wr");
  endtask

  task automatic do_rd(logic [7:0] a, bit drop);
    int t0;
    send_byte(8'hBB, $urandom_range(0, 2));
    send_byte(a, 0);
    t0 = last_rx_cyc;
    if (drop) send_byte(8'hAA, 0);
    exp_rd.push_back(a[3:0]);
    exp_tx.push_back(ref_regs[a[3:0]]);
    settle();
    if (mon_rdc.size() == 1) chk("rd_en_delay", 32'(mon_rdc[0] - t0), 32'd1);
    if (mon_txc.size() == 1) chk("rd_latency", 32'(mon_txc[0] - t0), 32'(3 + rf_lat));
    compare_all("rd");
  endtask

  task automatic alu_tail(string tag, logic [3:0] f, logic [15:0] r);
    exp_alu.push_back(f);
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
    settle();
    chk({tag, ".clk_en_cycles"}, 32'(ce_cnt), 32'(alu_lat + 1));
    chk({tag, ".clk_en_at_alu_en"}, 32'(ce_at_en), 32'd1);
    if (mon_txc.size() == 2) chk({tag, ".tx_gap"}, 32'(mon_txc[1] - mon_txc[0]), 32'd1);
    compare_all(tag);
  endtask

  task automatic do_alu(logic [7:0] a, logic [7:0] b, logic [7:0] f);
    ce_cnt = 0;
    send_byte(8'hCC, $urandom_range(0, 2));
    send_byte(a, $urandom_range(0, 2));
    send_byte(b, $urandom_range(0, 2));
    send_byte(f, 0);
    exp_wr.push_back({4'h0, a});
    exp_wr.push_back({4'h1, b});
    ref_regs[0] = a; ref_regs[1] = b;
    alu_tail("alu", f[3:0], alu_ref(a, b, f[3:0]));
  endtask

  task automatic do_dd(logic [7:0] f);
    ce_cnt = 0;
    send_byte(8'hDD, $urandom_range(0, 2));
    send_byte(f, 0);
    alu_tail("alu_dd", f[3:0], alu_ref(ref_regs[0], ref_regs[1], f[3:0]));
  endtask

  initial begin
    int n;
    logic [7:0] junk;
    repeat (3) step();
    chk("reset_outputs", out_vec(), 32'd0);
    RST = 1'b1;
    repeat (2) step();

    // Directed: write, write+read, ALU with operands.
    rf_lat = 2; alu_lat = 3;
    do_wr(8'h05, 8'h3C);
    do_wr(8'h07, 8'h81);
    do_rd(8'h07, 1'b0);
    do_alu(8'h0A, 8'h14, 8'h00);

    // Backpressure: result held while the TX FIFO is full.
    alu_force = 1'b1; alu_force_val = 16'h1234; FIFO_FULL = 1'b1; ce_cnt = 0;
    send_byte(8'hDD, 1);
    send_byte(8'h02, 0);
    exp_alu.push_back(4'h2); exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    n = 0;
    while (!CLK_EN && n < 50) begin step(); n++; end
    while (CLK_EN && n < 100) begin step(); n++; end
    repeat (5) step();
    chk("bp_no_push_while_full", 32'(mon_tx.size()), 32'd0);
    FIFO_FULL = 1'b0;
    settle();
    chk("bp_push_while_full", 32'(full_viol), 32'd0);
    if (mon_txc.size() == 2) chk("bp_tx_gap", 32'(mon_txc[1] - mon_txc[0]), 32'd1);
    compare_all("bp");
    alu_force = 1'b0;

    // Illegal byte in IDLE, then a byte dropped during RD_WAIT.
    send_byte(8'h55, 2);
    settle();
    compare_all("illegal");
    rf_lat = 6;
    do_rd(8'h03, 1'b1);
    do_wr(8'h02, 8'h09);
    rf_lat = 2;
    do_rd(8'h02, 1'b0);

    // Reset while waiting on the ALU.
    alu_lat = 30;
    send_byte(8'hDD, 1);
    send_byte(8'h03, 0);
    exp_alu.push_back(4'h3);
    n = 0;
    while (!CLK_EN && n < 20) begin step(); n++; end
    chk("rst_mid_in_alu_wait", 32'(CLK_EN), 32'd1);
    repeat (3) step();
    RST = 1'b0;
    #1;
    chk("rst_mid_outputs", out_vec(), 32'd0);
    repeat (2) step();
    RST = 1'b1;
    repeat (40) step();
    compare_all("rst_mid");
    alu_lat = 3;
    do_wr(8'h01, 8'hFF);
    do_rd(8'h01, 1'b0);

    // Randomized command mix against the reference model.
    for (int k = 0; k < 24; k++) begin
      rf_lat  = $urandom_range(1, 4);
      alu_lat = $urandom_range(1, 5);
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'hAA || junk == 8'hBB || junk == 8'hCC || junk == 8'hDD) junk = 8'h00;
        send_byte(junk, 1);
      end
      case ($urandom_range(0, 3))
        0:       do_wr(8'($urandom), 8'($urandom));
        1:       do_rd(8'($urandom), 1'b0);
        2:       do_alu(8'($urandom), 8'($urandom), 8'($urandom));
        default: do_dd(8'($urandom));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_sys_ctrl.md
Name: uart_sys_ctrl

Overview:
- Command sequencer behind the UART receiver.
- Consumes the received byte stream (P_DATA/Data_Valid, already synchronized into this clock domain) and decodes framed commands.
- Drives the register file and ALU, then pushes response bytes into the TX FIFO.
- Single clock domain; sits between the UART RX/TX path and the system datapath.

Parameters:
- DATA_WIDTH, 8, width of UART bytes, register data and TX data.
- ADDR_WIDTH, 4, register-file address width.
- ALU_OUT_WIDTH, 16, ALU result width; sent as two bytes.
- ALU_FUN_WIDTH, 4, ALU function-select width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-low.
- RX_P_DATA  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid while it is high.
- RdData  in  DATA_WIDTH  register-file read data.
- RdData_Valid  in  1  one-cycle strobe from the register file.
- ALU_OUT  in  ALU_OUT_WIDTH  ALU result.
- OUT_Valid  in  1  one-cycle strobe from the ALU.
- FIFO_FULL  in  1  TX FIFO full.
- WrEn  out  1  register write strobe.
- RdEn  out  1  register read strobe.
- Address  out  ADDR_WIDTH  register address.
- WrData  out  DATA_WIDTH  register write data.
- ALU_EN  out  1  ALU start strobe.
- ALU_FUN  out  ALU_FUN_WIDTH  ALU function.
- CLK_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  DATA_WIDTH  byte pushed to the TX FIFO.
- TX_D_VLD  out  1  TX FIFO write strobe.

Behaviour:
- Reset (RST=0, async): state=IDLE; all outputs 0; internal address/result registers 0.
- Command bytes are decoded only in IDLE:
  - 0xAA = reg write: addr byte, then data byte.
  - 0xBB = reg read: addr byte.
  - 0xCC = ALU with operands: A byte, B byte, func byte.
  - 0xDD = ALU without operands: func byte.
  - Any other byte in IDLE is ignored; state stays IDLE.
- Address uses RX_P_DATA[ADDR_WIDTH-1:0]; upper bits are ignored. ALU_FUN uses RX_P_DATA[ALU_FUN_WIDTH-1:0].
- States:
  - IDLE
  - WR_ADDR: latch address.
  - WR_DATA: on byte, WrEn=1 for one cycle with Address=latched, WrData=byte -> IDLE.
  - RD_ADDR: on byte, RdEn=1 for one cycle -> RD_WAIT.
  - RD_WAIT: on RdData_Valid, latch RdData -> TX_RD.
  - TX_RD: one response byte.
  - ALU_A: on byte, write operand A to address 0 (WrEn pulse).
  - ALU_B: on byte, write operand B to address 1 (WrEn pulse).
  - ALU_FN: on byte, ALU_EN=1 for one cycle with ALU_FUN=func; CLK_EN rises in that same cycle -> ALU_WAIT.
  - ALU_WAIT: CLK_EN held high; on OUT_Valid, latch ALU_OUT and drop CLK_EN next cycle -> TX_LO.
  - TX_LO: low byte of the latched result.
  - TX_HI: upper byte of the latched result.
- Transitions: 0xCC: IDLE->ALU_A->ALU_B->ALU_FN. 0xDD: IDLE->ALU_FN directly.
- TX states:
  - TX_D_VLD=1 for exactly one cycle, only when FIFO_FULL=0; TX_P_DATA valid in that cycle.
  - While FIFO_FULL=1, hold state with TX_D_VLD=0.
  - TX_RD->IDLE; TX_LO->TX_HI->IDLE.
- Timing:
  - WrEn/RdEn/ALU_EN/TX_D_VLD are registered and assert the cycle after the triggering strobe.
  - Read latency from the addr byte strobe to TX_D_VLD is 3 cycles plus register-file latency (FIFO not full).
- Simultaneous and boundary events:
  - RX_D_VLD in RD_WAIT/ALU_WAIT/TX_* is dropped (no buffering).
  - RdData_Valid/OUT_Valid outside their wait states are ignored.
  - OUT_Valid in the same cycle as ALU_EN is impossible by ALU contract; no handling required.
  - Reset mid-command aborts to IDLE with all strobes low; a partial command is discarded.
- Strobes never stay high for more than one cycle per event.

Test Plan:
- Reg write: bytes AA,05,3C -> one WrEn pulse with Address=5, WrData=0x3C; no TX_D_VLD; back to IDLE.
- Reg read: AA,07,81 then BB,07; register file returns 0x81 two cycles after RdEn -> one TX_D_VLD with TX_P_DATA=0x81.
- ALU with operands: CC,0A,14,00; ALU returns 0x001E after 3 cycles -> WrEn at addr 0 (0x0A) and addr 1 (0x14); ALU_EN with ALU_FUN=0; CLK_EN high until OUT_Valid; TX bytes 0x1E then 0x00.
- FIFO backpressure: DD,02 with ALU_OUT=0x1234 and FIFO_FULL=1 for 5 cycles -> no TX_D_VLD while full; then 0x34, 0x12 on consecutive push cycles.
- Illegal/dropped bytes: 0x55 in IDLE ignored; byte sent during RD_WAIT dropped -> the subsequent command AA,02,09 executes correctly.
- Reset mid-op: assert RST=0 in ALU_WAIT -> CLK_EN, ALU_EN, TX_D_VLD at 0 immediately; after release, AA,01,FF performs a normal write.
